// File: rtl/vga_pkg.sv
// Shared defaults, clear-engine state type and address-width helper
// for the VGA frame buffer.
package vga_pkg;

  localparam int unsigned H_RES_DEF    = 640;
  localparam int unsigned V_RES_DEF    = 480;
  localparam int unsigned PIX_W_DEF    = 24;
  localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clear_state_t;

  // Width of a coordinate field; never narrower than one bit.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame-buffer bank: simple dual-port RAM with a single write port
// and a registered read port.
module fb_bank #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage is deliberately left out of reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_framebuf.sv
// Writable, optionally double-buffered frame buffer feeding vga_ctrl:
// scan-address read port, pixel writes, back-buffer clear, tear-free swap.
module vga_framebuf
  import vga_pkg::*;
#(
  parameter int unsigned      H_RES      = H_RES_DEF,
  parameter int unsigned      V_RES      = V_RES_DEF,
  parameter int unsigned      SCALE_LOG2 = 0,
  parameter int unsigned      PIX_W      = PIX_W_DEF,
  parameter int unsigned      DOUBLE_BUF = 1,
  parameter logic [PIX_W-1:0] BG_COLOR   = PIX_W'(BG_COLOR_DEF),
  localparam int unsigned     FB_W       = H_RES >> SCALE_LOG2,
  localparam int unsigned     FB_H       = V_RES >> SCALE_LOG2,
  localparam int unsigned     XW         = addr_bits(FB_W),
  localparam int unsigned     YW         = addr_bits(FB_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_addr,
  input  logic [9:0]       v_addr,
  output logic [PIX_W-1:0] vga_data,
  input  logic             frame_end,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             clr_req,
  input  logic [PIX_W-1:0] clr_color,
  output logic             clr_done,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic             front_sel
);

  localparam int unsigned AW = XW + YW;

  clear_state_t     r_state;
  logic [AW-1:0]    r_clr_addr;
  logic [PIX_W-1:0] r_clr_color;
  logic             r_clr_done;
  logic             r_wr_ready;
  logic             r_front_sel;
  logic             r_swap_pending;
  logic             r_rd_sel;
  logic             r_rd_bg;

  logic             w_clearing;
  logic             w_wr_in_range;
  logic             w_user_we;
  logic             w_we;
  logic             w_back_sel;
  logic             w_rd_oor;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic [PIX_W-1:0] w_wdata;
  logic [PIX_W-1:0] w_q0;
  logic [PIX_W-1:0] w_q1;

  // Shared write port: the clear engine owns it while clearing.
  assign w_clearing    = (r_state == CLR_CLEAR);
  assign w_wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign w_user_we     = wr_en && r_wr_ready && w_wr_in_range;
  assign w_we          = w_clearing || w_user_we;
  assign w_waddr       = w_clearing ? r_clr_addr  : {wr_y, wr_x};
  assign w_wdata       = w_clearing ? r_clr_color : wr_data;
  assign w_back_sel    = (DOUBLE_BUF != 0) ? ~r_front_sel : 1'b0;

  assign w_raddr  = {YW'(v_addr >> SCALE_LOG2), XW'(h_addr >> SCALE_LOG2)};
  assign w_rd_oor = (32'(h_addr) >= H_RES) || (32'(v_addr) >= V_RES);

  // Clear engine: one back-buffer word per cycle, done pulse after the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLR_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      r_clr_done  <= 1'b0;
      r_wr_ready  <= 1'b1;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        CLR_IDLE: begin
          if (clr_req) begin
            r_state     <= CLR_CLEAR;
            r_clr_addr  <= '0;
            r_clr_color <= clr_color;
            r_wr_ready  <= 1'b0;
          end
        end
        CLR_CLEAR: begin
          if (&r_clr_addr) begin
            r_state    <= CLR_IDLE;
            r_clr_done <= 1'b1;
            r_wr_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
        end
        default: begin
          r_state    <= CLR_IDLE;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // Swap only on an idle frame boundary; a request arriving with that
  // boundary stays pending for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (DOUBLE_BUF != 0) begin
      if (frame_end && r_swap_pending && !w_clearing) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= swap_req;
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  // Select and blanking flags delayed to line up with the bank read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel <= 1'b0;
      r_rd_bg  <= 1'b0;
    end else begin
      r_rd_sel <= r_front_sel;
      r_rd_bg  <= w_rd_oor;
    end
  end

  fb_bank #(
    .AW (AW),
    .DW (PIX_W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we && !w_back_sel),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_q0)
  );

  if (DOUBLE_BUF != 0) begin : g_dbl
    fb_bank #(
      .AW (AW),
      .DW (PIX_W)
    ) u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we && w_back_sel),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_q1)
    );
  end else begin : g_sgl
    assign w_q1 = '0;
  end

  assign vga_data     = r_rd_bg ? BG_COLOR : (r_rd_sel ? w_q1 : w_q0);
  assign wr_ready     = r_wr_ready;
  assign clr_done     = r_clr_done;
  assign swap_pending = r_swap_pending;
  assign front_sel    = r_front_sel;

endmodule

// File: tb/tb_vga_framebuf.sv
// Directed bench: a double-buffered unscaled instance (A) and a
// single-buffered 2x-scaled instance (B) sharing clock, reset and scan address.
module tb_vga_framebuf;

  localparam logic [23:0] BG_A = 24'h0A0B0C;
  localparam logic [23:0] BG_B = 24'h0F0F0F;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [23:0] exp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_addr, v_addr;

  logic        fe_a, sw_a, wr_en_a, clr_req_a;
  logic [4:0]  wr_x_a, wr_y_a;
  logic [23:0] wr_data_a, clr_color_a, vga_a;
  logic        wr_ready_a, clr_done_a, pend_a, front_a;

  logic        fe_b, sw_b, wr_en_b, clr_req_b;
  logic [3:0]  wr_x_b, wr_y_b;
  logic [23:0] wr_data_b, clr_color_b, vga_b;
  logic        wr_ready_b, clr_done_b, pend_b, front_b;

  int n_checks = 0;
  int n_fail   = 0;
  rd_vec_t rq[$];
  rd_vec_t vec_b[11];

  always #5 clk = ~clk;

  vga_framebuf #(
    .H_RES(24), .V_RES(24), .SCALE_LOG2(0), .PIX_W(24), .DOUBLE_BUF(1), .BG_COLOR(BG_A)
  ) dut_a (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_a),
    .frame_end(fe_a), .wr_en(wr_en_a), .wr_x(wr_x_a), .wr_y(wr_y_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a), .clr_req(clr_req_a), .clr_color(clr_color_a), .clr_done(clr_done_a),
    .swap_req(sw_a), .swap_pending(pend_a), .front_sel(front_a)
  );

  vga_framebuf #(
    .H_RES(32), .V_RES(24), .SCALE_LOG2(1), .PIX_W(24), .DOUBLE_BUF(0), .BG_COLOR(BG_B)
  ) dut_b (
    .clk(clk), .rst(rst), .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_b),
    .frame_end(fe_b), .wr_en(wr_en_b), .wr_x(wr_x_b), .wr_y(wr_y_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b), .clr_req(clr_req_b), .clr_color(clr_color_b), .clr_done(clr_done_b),
    .swap_req(sw_b), .swap_pending(pend_b), .front_sel(front_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int h, input int v, input logic [23:0] exp);
    rd_vec_t e;
    e.h = 10'(h);
    e.v = 10'(v);
    e.exp = exp;
    rq.push_back(e);
  endtask

  // Address i is driven at a falling edge; its pixel must appear exactly
  // one rising edge later, i.e. while address i+1 is being driven.
  task automatic run_reads(input bit use_b, input string tag);
    for (int i = 0; i <= rq.size(); i++) begin
      @(negedge clk);
      if (i < rq.size()) begin
        h_addr = rq[i].h;
        v_addr = rq[i].v;
      end
      #1;
      if (i > 0)
        check($sformatf("%s[%0d]", tag, i - 1), 32'(use_b ? vga_b : vga_a), 32'(rq[i-1].exp));
    end
    rq.delete();
  endtask

  task automatic drive_a(input bit sw, input bit fe, input bit we,
                         input int x, input int y, input logic [23:0] d);
    @(negedge clk);
    sw_a = sw; fe_a = fe; wr_en_a = we;
    wr_x_a = 5'(x); wr_y_a = 5'(y); wr_data_a = d;
    @(negedge clk);
    sw_a = 1'b0; fe_a = 1'b0; wr_en_a = 1'b0;
  endtask

  task automatic drive_b(input bit sw, input bit fe, input bit we,
                         input int x, input int y, input logic [23:0] d);
    @(negedge clk);
    sw_b = sw; fe_b = fe; wr_en_b = we;
    wr_x_b = 4'(x); wr_y_b = 4'(y); wr_data_b = d;
    @(negedge clk);
    sw_b = 1'b0; fe_b = 1'b0; wr_en_b = 1'b0;
  endtask

  // Starts a clear, counts busy cycles (bounded), optionally pulses A's
  // frame_end at busy cycle fe_at, and checks the done pulse.
  task automatic do_clear(input bit use_b, input logic [23:0] col, input int exp_busy,
                          input int fe_at, input string tag);
    int busy;
    int early;
    busy = 0;
    early = 0;
    @(negedge clk);
    if (use_b) begin clr_req_b = 1'b1; clr_color_b = col; end
    else       begin clr_req_a = 1'b1; clr_color_a = col; end
    @(negedge clk);
    clr_req_a = 1'b0;
    clr_req_b = 1'b0;
    while (!(use_b ? wr_ready_b : wr_ready_a) && busy < 5000) begin
      busy++;
      if (use_b ? clr_done_b : clr_done_a) early++;
      fe_a = !use_b && (busy == fe_at);
      @(negedge clk);
    end
    fe_a = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, "_done_early"}, 32'(early), 32'd0);
    check({tag, "_done_pulse"}, 32'(use_b ? clr_done_b : clr_done_a), 32'd1);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(use_b ? clr_done_b : clr_done_a), 32'd0);
  endtask

  initial begin
    int pulses;
    vec_b[0]  = '{10'd6,  10'd8,  24'h00FF00};
    vec_b[1]  = '{10'd7,  10'd8,  24'h00FF00};
    vec_b[2]  = '{10'd6,  10'd9,  24'h00FF00};
    vec_b[3]  = '{10'd7,  10'd9,  24'h00FF00};
    vec_b[4]  = '{10'd5,  10'd8,  24'h111111};
    vec_b[5]  = '{10'd8,  10'd8,  24'h111111};
    vec_b[6]  = '{10'd6,  10'd7,  24'h111111};
    vec_b[7]  = '{10'd6,  10'd10, 24'h111111};
    vec_b[8]  = '{10'd32, 10'd0,  BG_B};
    vec_b[9]  = '{10'd0,  10'd24, BG_B};
    vec_b[10] = '{10'd31, 10'd23, 24'h111111};

    rst = 1'b1; h_addr = '0; v_addr = '0;
    fe_a = 0; sw_a = 0; wr_en_a = 0; clr_req_a = 0; wr_x_a = '0; wr_y_a = '0;
    wr_data_a = '0; clr_color_a = '0;
    fe_b = 0; sw_b = 0; wr_en_b = 0; clr_req_b = 0; wr_x_b = '0; wr_y_b = '0;
    wr_data_b = '0; clr_color_b = '0;

    repeat (2) @(negedge clk);
    check("rst_vga_a",   32'(vga_a), 32'd0);
    check("rst_front_a", 32'(front_a), 32'd0);
    check("rst_pend_a",  32'(pend_a), 32'd0);
    check("rst_done_a",  32'(clr_done_a), 32'd0);
    check("rst_ready_a", 32'(wr_ready_a), 32'd1);
    check("rst_vga_b",   32'(vga_b), 32'd0);
    check("rst_ready_b", 32'(wr_ready_b), 32'd1);
    rst = 1'b0;

    // B: single buffer, 2x scaling; swap requests are ignored.
    do_clear(1'b1, 24'h111111, 256, -1, "clrB");
    drive_b(1'b1, 1'b0, 1'b0, 0, 0, '0);
    check("b_swap_ignored_pend", 32'(pend_b), 32'd0);
    drive_b(1'b0, 1'b1, 1'b0, 0, 0, '0);
    check("b_front_tied", 32'(front_b), 32'd0);
    drive_b(1'b0, 1'b0, 1'b1, 3, 4, 24'h00FF00);
    for (int k = 0; k < 11; k++) rq.push_back(vec_b[k]);
    run_reads(1'b1, "rdB");

    // A: clear back buffer 1, swap it in, scan everything.
    do_clear(1'b0, 24'h123456, 1024, -1, "clrA1");
    drive_a(1'b1, 1'b0, 1'b0, 0, 0, '0);
    check("a_pend_set", 32'(pend_a), 32'd1);
    check("a_front_hold", 32'(front_a), 32'd0);
    drive_a(1'b0, 1'b1, 1'b0, 0, 0, '0);
    check("a_swap1_front", 32'(front_a), 32'd1);
    check("a_swap1_pend", 32'(pend_a), 32'd0);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 24; x++) push(x, y, 24'h123456);
    push(700, 5, BG_A); push(24, 0, BG_A); push(0, 24, BG_A);
    push(23, 23, 24'h123456); push(1023, 1023, BG_A);
    run_reads(1'b0, "scanA1");

    // Fill buffer 0, write a pixel plus two out-of-range writes, swap.
    do_clear(1'b0, 24'h222222, 1024, -1, "clrA2");
    drive_a(1'b0, 1'b0, 1'b1, 10, 20, 24'hFF0000);
    drive_a(1'b0, 1'b0, 1'b1, 24, 3, 24'hDEADBE);
    drive_a(1'b0, 1'b0, 1'b1, 3, 24, 24'hBEEF00);
    drive_a(1'b1, 1'b0, 1'b0, 0, 0, '0);
    drive_a(1'b0, 1'b1, 1'b0, 0, 0, '0);
    check("a_swap2_front", 32'(front_a), 32'd0);
    drive_a(1'b0, 1'b0, 1'b1, 5, 5, 24'hABCDEF);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 24; x++)
        push(x, y, (x == 10 && y == 20) ? 24'hFF0000 : 24'h222222);
    push(700, 5, BG_A);
    run_reads(1'b0, "scanA2");

    // Request coinciding with frame_end is deferred; a write in the swap
    // cycle lands in the outgoing back buffer.
    drive_a(1'b1, 1'b1, 1'b0, 0, 0, '0);
    check("a_same_cycle_front", 32'(front_a), 32'd0);
    check("a_same_cycle_pend", 32'(pend_a), 32'd1);
    drive_a(1'b0, 1'b1, 1'b1, 1, 1, 24'h0000FF);
    check("a_swap3_front", 32'(front_a), 32'd1);
    check("a_swap3_pend", 32'(pend_a), 32'd0);
    push(1, 1, 24'h0000FF); push(5, 5, 24'hABCDEF);
    push(2, 1, 24'h123456); push(10, 20, 24'h123456);
    run_reads(1'b0, "rdA3");

    // frame_end during a clear must not swap.
    drive_a(1'b1, 1'b0, 1'b0, 0, 0, '0);
    do_clear(1'b0, 24'h555555, 1024, 100, "clrA3");
    check("a_midclear_front", 32'(front_a), 32'd1);
    check("a_midclear_pend", 32'(pend_a), 32'd1);
    drive_a(1'b0, 1'b1, 1'b0, 0, 0, '0);
    check("a_after_clear_front", 32'(front_a), 32'd0);
    check("a_after_clear_pend", 32'(pend_a), 32'd0);
    push(10, 20, 24'h555555); push(0, 0, 24'h555555); push(23, 23, 24'h555555);
    run_reads(1'b0, "rdA4");

    // Reset in the middle of a clear.
    drive_a(1'b1, 1'b0, 1'b0, 0, 0, '0);
    drive_a(1'b0, 1'b1, 1'b0, 0, 0, '0);
    check("a_pre_rst_front", 32'(front_a), 32'd1);
    @(negedge clk); clr_req_a = 1'b1; clr_color_a = 24'h777777;
    @(negedge clk); clr_req_a = 1'b0; sw_a = 1'b1;
    @(negedge clk); sw_a = 1'b0;
    repeat (10) @(negedge clk);
    check("a_pre_rst_ready", 32'(wr_ready_a), 32'd0);
    check("a_pre_rst_pend", 32'(pend_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("a_rst_ready", 32'(wr_ready_a), 32'd1);
    check("a_rst_front", 32'(front_a), 32'd0);
    check("a_rst_pend", 32'(pend_a), 32'd0);
    check("a_rst_done", 32'(clr_done_a), 32'd0);
    check("a_rst_vga", 32'(vga_a), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (1200) begin
      @(negedge clk);
      if (clr_done_a) pulses++;
    end
    check("a_aborted_no_done", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
